// File: rtl/cnn_pixel_streamer_if.sv
// cnn_pixel_streamer_if
// Pixel stream handshake between the SRAM frame reader and the CNN line buffer.
//   pixel_valid  master -> slave  head pixel is valid
//   pixel_ready  slave  -> master downstream accepts the head pixel
//   pixel_data   master -> slave  pixel value (DATA_WIDTH bits)
//   pixel_eol    master -> slave  pixel is the last column of its row
//   pixel_last   master -> slave  pixel is the last pixel of the frame
interface cnn_pixel_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [DATA_WIDTH-1:0] pixel_data;
  logic                  pixel_eol;
  logic                  pixel_last;

  modport master (
    output pixel_valid,
    output pixel_data,
    output pixel_eol,
    output pixel_last,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    input  pixel_data,
    input  pixel_eol,
    input  pixel_last,
    output pixel_ready
  );
endinterface

// File: rtl/cnn_pixel_streamer.sv
// cnn_pixel_streamer
// Reads one WIDTH x HEIGHT frame from a single-port SRAM in raster order and
// streams it out through a 2-entry FIFO with valid/ready backpressure.
// Optional build macro CNN_PIXEL_STREAMER_ZERO_PAD_EN adds a 1-pixel zero
// border, giving a (WIDTH+2) x (HEIGHT+2) output frame.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        1-cycle frame request, ignored while busy or in the done cycle
//   base_addr    SRAM word address of pixel (0,0), sampled on start
//   busy         frame in progress
//   done         1-cycle pulse after the last pixel handshake
//   mem_req      SRAM read strobe; mem_addr its address
//   mem_rdata    SRAM read data, valid the cycle after mem_req
//   pix          pixel stream (master side of cnn_pixel_streamer_if)
module cnn_pixel_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  cnn_pixel_streamer_if.master  pix
);

`ifdef CNN_PIXEL_STREAMER_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int COLS  = WIDTH + 2 * PAD;
  localparam int ROWS  = HEIGHT + 2 * PAD;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [ROW_W-1:0]               row_q, row_d;
  logic [COL_W-1:0]               col_q, col_d;
  logic                           done_q, done_d;
  // One-deep issue pipeline: an entry issued last cycle lands in the FIFO now.
  logic                           infl_q, infl_d;
  logic                           infl_eol_q, infl_eol_d;
  logic                           infl_last_q, infl_last_d;
  logic                           infl_zero_q, infl_zero_d;
  logic [1:0][DATA_WIDTH-1:0]     fifo_data_q, fifo_data_d;
  logic [1:0]                     fifo_eol_q, fifo_eol_d;
  logic [1:0]                     fifo_last_q, fifo_last_d;
  logic                           rd_ptr_q, rd_ptr_d;
  logic                           wr_ptr_q, wr_ptr_d;
  logic [1:0]                     count_q, count_d;

  logic                           fifo_valid;
  logic                           pop;
  logic                           issue;
  logic                           border;
  logic                           pos_eol;
  logic                           pos_last;
  logic [2:0]                     used;

  always_comb begin
    border = 1'b0;
`ifdef CNN_PIXEL_STREAMER_ZERO_PAD_EN
    border = (row_q == '0) || (row_q == ROW_LAST) ||
             (col_q == '0) || (col_q == COL_LAST);
`endif
  end

  always_comb begin
    fifo_valid = (count_q != 2'd0);
    pop        = fifo_valid && pix.pixel_ready;
    pos_eol    = (col_q == COL_LAST);
    pos_last   = pos_eol && (row_q == ROW_LAST);
    // The slot freed by this cycle's pop is reusable immediately, which is
    // what allows one pixel per cycle with a budget of only two entries.
    used       = {1'b0, count_q} - {2'b0, pop} + {2'b0, infl_q};

    state_d     = state_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    mem_req     = 1'b0;
    fifo_data_d = fifo_data_q;
    fifo_eol_d  = fifo_eol_q;
    fifo_last_d = fifo_last_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN: begin
        if (used < 3'd2) begin
          issue   = 1'b1;
          mem_req = !border;
          if (!border) addr_d = addr_q + ADDR_WIDTH'(1);
          if (pos_eol) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (pos_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    infl_d      = issue;
    infl_eol_d  = issue && pos_eol;
    infl_last_d = issue && pos_last;
    infl_zero_d = issue && border;

    if (infl_q) begin
      fifo_data_d[wr_ptr_q] = infl_zero_q ? '0 : mem_rdata;
      fifo_eol_d[wr_ptr_q]  = infl_eol_q;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, infl_q} - {1'b0, pop};
  end

  always_comb begin
    busy            = (state_q != S_IDLE);
    done            = done_q;
    mem_addr        = addr_q;
    pix.pixel_valid = fifo_valid;
    pix.pixel_data  = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
    pix.pixel_eol   = fifo_valid && fifo_eol_q[rd_ptr_q];
    pix.pixel_last  = fifo_valid && fifo_last_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_eol_q  <= 1'b0;
      infl_last_q <= 1'b0;
      infl_zero_q <= 1'b0;
      fifo_data_q <= '0;
      fifo_eol_q  <= '0;
      fifo_last_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_q      <= done_d;
      infl_q      <= infl_d;
      infl_eol_q  <= infl_eol_d;
      infl_last_q <= infl_last_d;
      infl_zero_q <= infl_zero_d;
      fifo_data_q <= fifo_data_d;
      fifo_eol_q  <= fifo_eol_d;
      fifo_last_q <= fifo_last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule
